// File: rtl/l1_event_buffer_mh_if.sv
// Bus between the pixel circular buffer / readout network and one L1 event buffer.
// The master side drives the write, prefetch, load and read controls; the slave is the buffer.
interface l1_event_buffer_mh_if #(
  parameter int ADDRWIDTH = 7,
  parameter int DATAWIDTH = 36,
  parameter int ERRWIDTH  = 2,
  parameter int CNTWIDTH  = 8
);
  logic                 dis;
  logic [DATAWIDTH-1:0] din;
  logic                 inHit;
  logic [ERRWIDTH-1:0]  errIn;
  logic                 wren;
  logic [ADDRWIDTH-1:0] wrAddr;
  logic                 preLoad;
  logic [ADDRWIDTH-1:0] rdAddr;
  logic                 load;
  logic                 read;
  logic                 unreadHit;
  logic                 outHit;
  logic [DATAWIDTH-1:0] dout;
  logic [ERRWIDTH-1:0]  outErr;
  logic [CNTWIDTH-1:0]  ovfCnt;

  modport master (
    output dis, din, inHit, errIn, wren, wrAddr, preLoad, rdAddr, load, read,
    input  unreadHit, outHit, dout, outErr, ovfCnt
  );

  modport slave (
    input  dis, din, inHit, errIn, wren, wrAddr, preLoad, rdAddr, load, read,
    output unreadHit, outHit, dout, outErr, ovfCnt
  );
endinterface

// File: rtl/l1_event_buffer_mh.sv
// Per-pixel L1 event buffer: one data word + error flags per BX slot, a hit bitmap
// with unread-overwrite counting, and a prefetch/load/read output stage.
module l1_event_buffer_mh #(
  parameter int ADDRWIDTH = 7,
  parameter int DATAWIDTH = 36,
  parameter int ERRWIDTH  = 2,
  parameter int CNTWIDTH  = 8,
  parameter bit ZEROSUPP  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  l1_event_buffer_mh_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDRWIDTH;
  localparam int WORDW = DATAWIDTH + ERRWIDTH;

  logic [DEPTH-1:0]     hit_mem_q;
  logic [WORDW-1:0]     data_mem [DEPTH];
  logic                 hit_pre_q;
  logic [ADDRWIDTH-1:0] rd_addr_q;
  logic                 out_hit_q;
  logic [DATAWIDTH-1:0] dout_q;
  logic [ERRWIDTH-1:0]  out_err_q;
  logic                 valid_q;
  logic [CNTWIDTH-1:0]  ovf_cnt_q;

  logic wr_en, pre_en, load_en, read_en, consume_en, consume_same, ovf_inc;

  assign wr_en   = bus.wren & ~bus.dis;
  assign pre_en  = bus.preLoad & ~bus.dis;
  assign load_en = bus.load & ~bus.dis;
  assign read_en = bus.read & ~bus.load & ~bus.dis;

  assign consume_en   = load_en & hit_pre_q;
  // A write landing on the slot being consumed keeps the new hit and is not an overwrite.
  assign consume_same = consume_en & (rd_addr_q == bus.wrAddr);
  assign ovf_inc      = wr_en & hit_mem_q[bus.wrAddr] & ~consume_same;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      always_ff @(posedge clk) begin
        if (reset) begin
          hit_mem_q[gi] <= 1'b0;
        end else if (wr_en && bus.wrAddr == ADDRWIDTH'(gi)) begin
          hit_mem_q[gi] <= bus.inHit;
        end else if (consume_en && rd_addr_q == ADDRWIDTH'(gi)) begin
          hit_mem_q[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en && bus.inHit) begin
      data_mem[bus.wrAddr] <= {bus.din, bus.errIn};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_pre_q <= 1'b0;
      rd_addr_q <= '0;
    end else if (pre_en) begin
      hit_pre_q <= hit_mem_q[bus.rdAddr];
      rd_addr_q <= bus.rdAddr;
    end
  end

  // Registered read of the data array doubles as the output word register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_hit_q <= 1'b0;
      dout_q    <= '0;
      out_err_q <= '0;
      valid_q   <= 1'b0;
    end else if (load_en) begin
      out_hit_q <= hit_pre_q;
      valid_q   <= ZEROSUPP ? hit_pre_q : 1'b1;
      if (hit_pre_q) begin
        {dout_q, out_err_q} <= data_mem[rd_addr_q];
      end else begin
        dout_q    <= '0;
        out_err_q <= '0;
      end
    end else if (read_en) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_cnt_q <= '0;
    end else if (ovf_inc && ovf_cnt_q != {CNTWIDTH{1'b1}}) begin
      ovf_cnt_q <= ovf_cnt_q + 1'b1;
    end
  end

  assign bus.unreadHit = valid_q & ~bus.dis;
  assign bus.outHit    = out_hit_q;
  assign bus.dout      = dout_q;
  assign bus.outErr    = out_err_q;
  assign bus.ovfCnt    = ovf_cnt_q;
endmodule
